// File: rtl/gerador_alvo_pkg.sv
// Shared definitions for the target generator: FSM state encoding, level codes,
// LFSR taps and the draw retry limit.
package gerador_alvo_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SORTEIA = 3'd1,
        PUBLICA = 3'd2,
        AGUARDA = 3'd3,
        PAUSA   = 3'd4
    } estado_t;

    localparam logic [1:0] NIVEL_0 = 2'd0;
    localparam logic [1:0] NIVEL_1 = 2'd1;
    localparam logic [1:0] NIVEL_2 = 2'd2;
    localparam logic [1:0] NIVEL_3 = 2'd3;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int RETRY_LIMIT = 8;

    // Next position in round-robin order, wrapping at n_pos.
    function automatic logic [2:0] proxima_pos(input logic [2:0] pos, input logic [3:0] n_pos);
        logic [3:0] soma;
        soma = {1'b0, pos} + 4'd1;
        return (soma >= n_pos) ? 3'd0 : soma[2:0];
    endfunction

endpackage

// File: rtl/gerador_alvo_lfsr.sv
// Free-running Galois LFSR; advances on every clock, reloads SEED on reset.
module lfsr_galois #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Q <= SEED;
        end else begin
            Q <= (Q >> 1) ^ (Q[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/gerador_alvo.sv
// Target LED generator: draws a new position after each won/lost point or level
// timeout, publishes it with a one-cycle level-counter reset pulse.
module gerador_alvo
    import gerador_alvo_pkg::*;
#(
    parameter int          N_POS        = 5,
    parameter int          COOLDOWN     = 8,
    parameter int          TIMEOUT_BASE = 3000,
    parameter int          TIMEOUT_N    = 12,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic       tick,
    input  logic [1:0] nivel_dificuldade,
    input  logic       ganhou_ponto,
    input  logic       perdeu_ponto,
    output logic [2:0] position_led,
    output logic       reset_nivel,
    output logic       novo_alvo,
    output logic       timeout,
    output logic       ativo,
    output logic [7:0] rodadas
);

    localparam int                 CW        = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CW-1:0]      COOL_MAX  = CW'(COOLDOWN);
    localparam logic [CW-1:0]      COOL_ONE  = CW'(1);
    localparam logic [3:0]         NPOS      = 4'(N_POS);
    localparam logic [2:0]         RETRY_MAX = 3'(RETRY_LIMIT - 1);
    localparam logic [TIMEOUT_N:0] LIM_2     = (TIMEOUT_N + 1)'(TIMEOUT_BASE);
    localparam logic [TIMEOUT_N:0] LIM_3     = (TIMEOUT_N + 1)'(TIMEOUT_BASE / 2);
    localparam logic [TIMEOUT_N:0] TMO_ONE   = (TIMEOUT_N + 1)'(1);

    estado_t              estado;
    logic [15:0]          lfsr;
    logic [2:0]           alvo;
    logic [2:0]           retry_cnt;
    logic [CW-1:0]        cool_cnt;
    logic [TIMEOUT_N-1:0] tmo_cnt;
    logic                 ganhou_prev;
    logic                 perdeu_prev;

    logic                 evento;
    logic [2:0]           candidato;
    logic                 candidato_ok;
    logic [2:0]           sequencial;
    logic [TIMEOUT_N:0]   tmo_prox;
    logic [TIMEOUT_N:0]   limite;
    logic                 nivel_com_tempo;
    logic                 unused_lfsr;

    lfsr_galois #(
        .WIDTH (16),
        .TAPS  (LFSR_TAPS),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .Q     (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:3];

    // Simultaneous rising edges on both inputs collapse into a single event.
    assign evento       = (ganhou_ponto & ~ganhou_prev) | (perdeu_ponto & ~perdeu_prev);
    assign candidato    = lfsr[2:0];
    assign candidato_ok = ({1'b0, candidato} < NPOS) && (candidato != position_led);
    assign sequencial   = proxima_pos(position_led, NPOS);

    assign nivel_com_tempo = (nivel_dificuldade == NIVEL_2) || (nivel_dificuldade == NIVEL_3);
    assign limite          = (nivel_dificuldade == NIVEL_3) ? LIM_3 : LIM_2;
    assign tmo_prox        = {1'b0, tmo_cnt} + TMO_ONE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= IDLE;
            position_led <= 3'd0;
            alvo         <= 3'd0;
            rodadas      <= 8'd0;
            reset_nivel  <= 1'b0;
            novo_alvo    <= 1'b0;
            timeout      <= 1'b0;
            ativo        <= 1'b0;
            retry_cnt    <= 3'd0;
            cool_cnt     <= '0;
            tmo_cnt      <= '0;
            ganhou_prev  <= 1'b0;
            perdeu_prev  <= 1'b0;
        end else begin
            ganhou_prev <= ganhou_ponto;
            perdeu_prev <= perdeu_ponto;
            reset_nivel <= 1'b0;
            novo_alvo   <= 1'b0;
            timeout     <= 1'b0;

            if (parar) begin
                estado    <= IDLE;
                ativo     <= 1'b0;
                retry_cnt <= 3'd0;
                cool_cnt  <= '0;
                tmo_cnt   <= '0;
            end else begin
                case (estado)
                    IDLE: begin
                        if (iniciar) begin
                            estado    <= SORTEIA;
                            ativo     <= 1'b1;
                            retry_cnt <= 3'd0;
                        end
                    end

                    SORTEIA: begin
                        if (nivel_dificuldade == NIVEL_0) begin
                            alvo      <= sequencial;
                            retry_cnt <= 3'd0;
                            estado    <= PUBLICA;
                        end else if (candidato_ok) begin
                            alvo      <= candidato;
                            retry_cnt <= 3'd0;
                            estado    <= PUBLICA;
                        end else if (retry_cnt == RETRY_MAX) begin
                            // Bound the draw time: fall back to the next position in order.
                            alvo      <= sequencial;
                            retry_cnt <= 3'd0;
                            estado    <= PUBLICA;
                        end else begin
                            retry_cnt <= retry_cnt + 3'd1;
                        end
                    end

                    PUBLICA: begin
                        position_led <= alvo;
                        reset_nivel  <= 1'b1;
                        novo_alvo    <= 1'b1;
                        if (rodadas != 8'hFF) begin
                            rodadas <= rodadas + 8'd1;
                        end
                        tmo_cnt <= '0;
                        estado  <= AGUARDA;
                    end

                    AGUARDA: begin
                        if (evento) begin
                            cool_cnt <= '0;
                            estado   <= PAUSA;
                        end else if (tick && nivel_com_tempo) begin
                            // Compared against the live level, so a lowered limit fires on the next tick.
                            if (tmo_prox >= limite) begin
                                timeout <= 1'b1;
                                tmo_cnt <= '0;
                                estado  <= SORTEIA;
                            end else begin
                                tmo_cnt <= tmo_prox[TIMEOUT_N-1:0];
                            end
                        end
                    end

                    PAUSA: begin
                        if (cool_cnt == COOL_MAX) begin
                            cool_cnt <= '0;
                            estado   <= SORTEIA;
                        end else begin
                            cool_cnt <= cool_cnt + COOL_ONE;
                        end
                    end

                    default: begin
                        estado <= IDLE;
                        ativo  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gerador_alvo.sv
// Directed bench for gerador_alvo: sequential targets, random draws, timeouts,
// edge handling, stop/restart and asynchronous reset.
module tb_gerador_alvo;

    localparam int N_POS        = 5;
    localparam int COOLDOWN     = 8;
    localparam int TIMEOUT_BASE = 100;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       parar;
    logic       tick;
    logic [1:0] nivel_dificuldade;
    logic       ganhou_ponto;
    logic       perdeu_ponto;
    logic [2:0] position_led;
    logic       reset_nivel;
    logic       novo_alvo;
    logic       timeout;
    logic       ativo;
    logic [7:0] rodadas;

    logic [2:0] exp_q[$];
    int         checks = 0;
    int         passes = 0;
    int         fails  = 0;
    int         rod_model = 0;
    int         lat;
    int         c1;
    int         c2;
    int         n_tmo;
    logic [2:0] pos_prev;

    gerador_alvo #(
        .N_POS        (N_POS),
        .COOLDOWN     (COOLDOWN),
        .TIMEOUT_BASE (TIMEOUT_BASE),
        .TIMEOUT_N    (12),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .iniciar           (iniciar),
        .parar             (parar),
        .tick              (tick),
        .nivel_dificuldade (nivel_dificuldade),
        .ganhou_ponto      (ganhou_ponto),
        .perdeu_ponto      (perdeu_ponto),
        .position_led      (position_led),
        .reset_nivel       (reset_nivel),
        .novo_alvo         (novo_alvo),
        .timeout           (timeout),
        .ativo             (ativo),
        .rodadas           (rodadas)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Returns the number of rising edges from the one sampling the stimulus to
    // the one that raised novo_alvo.
    task automatic wait_novo(input int budget, output int clocks);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clock);
            n++;
            if (novo_alvo === 1'b1) seen = 1'b1;
        end
        check("novo_alvo_seen", 32'(seen), 1);
        clocks = n - 1;
    endtask

    task automatic wait_timeout(input int budget, output int n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clock);
            n++;
            if (timeout === 1'b1) seen = 1'b1;
        end
        check("timeout_seen", 32'(seen), 1);
    endtask

    // Called at the sample where novo_alvo is high; consumes one more cycle.
    task automatic check_publish();
        logic [2:0] e;
        check("reset_nivel_with_novo", 32'(reset_nivel), 1);
        check("timeout_low_at_publish", 32'(timeout), 0);
        rod_model = (rod_model < 255) ? rod_model + 1 : 255;
        check("rodadas", 32'(rodadas), rod_model);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("position_led", 32'(position_led), 32'(e));
        end
        @(negedge clock);
        check("pulse_width", 32'({novo_alvo, reset_nivel}), 0);
    endtask

    task automatic count_novo(input int n, output int c);
        logic [2:0] e;
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (novo_alvo === 1'b1) begin
                c++;
                rod_model = (rod_model < 255) ? rod_model + 1 : 255;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("position_led_counted", 32'(position_led), 32'(e));
                end
            end
        end
    endtask

    task automatic level0_event(input logic [2:0] e);
        exp_q.push_back(e);
        ganhou_ponto = 1'b1;
        wait_novo(COOLDOWN + 20, lat);
        check("event_latency", lat, COOLDOWN + 3);
        check_publish();
        ganhou_ponto = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset             = 1'b0;
        iniciar           = 1'b0;
        parar             = 1'b0;
        tick              = 1'b0;
        nivel_dificuldade = 2'd0;
        ganhou_ponto      = 1'b0;
        perdeu_ponto      = 1'b0;
        #2 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("rst_position", 32'(position_led), 0);
        check("rst_rodadas", 32'(rodadas), 0);
        check("rst_ativo", 32'(ativo), 0);
        check("rst_pulses", 32'({reset_nivel, novo_alvo, timeout}), 0);
        reset = 1'b0;
        @(negedge clock);

        // Level 0: sequential targets 1,2,3,4,0
        nivel_dificuldade = 2'd0;
        iniciar = 1'b1;
        exp_q.push_back(3'd1);
        wait_novo(10, lat);
        check("start_latency", lat, 2);
        check("ativo_running", 32'(ativo), 1);
        check_publish();
        iniciar = 1'b0;
        level0_event(3'd2);
        level0_event(3'd3);
        level0_event(3'd4);
        level0_event(3'd0);

        // Held-high level triggers once
        exp_q.push_back(3'd1);
        ganhou_ponto = 1'b1;
        count_novo(200, c1);
        check("held_high_count", c1, 1);
        check("held_rodadas", 32'(rodadas), rod_model);
        ganhou_ponto = 1'b0;
        @(negedge clock);

        // Simultaneous edges are one event
        exp_q.push_back(3'd2);
        ganhou_ponto = 1'b1;
        perdeu_ponto = 1'b1;
        count_novo(60, c1);
        check("simultaneous_count", c1, 1);
        ganhou_ponto = 1'b0;
        perdeu_ponto = 1'b0;
        @(negedge clock);

        // A second edge while pausing is discarded
        exp_q.push_back(3'd3);
        ganhou_ponto = 1'b1;
        count_novo(3, c1);
        perdeu_ponto = 1'b1;
        count_novo(60, c2);
        check("pausa_edge_count", c1 + c2, 1);
        ganhou_ponto = 1'b0;
        perdeu_ponto = 1'b0;
        @(negedge clock);

        // Stop during PAUSA, then restart keeps rodadas
        ganhou_ponto = 1'b1;
        count_novo(4, c1);
        check("stop_no_early_novo", c1, 0);
        parar = 1'b1;
        @(negedge clock);
        check("stop_ativo", 32'(ativo), 0);
        parar        = 1'b0;
        ganhou_ponto = 1'b0;
        count_novo(100, c1);
        check("stop_no_novo", c1, 0);
        check("stop_position_held", 32'(position_led), 3);
        check("stop_rodadas_held", 32'(rodadas), rod_model);
        exp_q.push_back(3'd4);
        iniciar = 1'b1;
        wait_novo(10, lat);
        check("restart_latency", lat, 2);
        check_publish();
        iniciar = 1'b0;

        // Level 1: random draws, range and no-repeat
        nivel_dificuldade = 2'd1;
        pos_prev = 3'd4;
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) ganhou_ponto = 1'b1;
            else            perdeu_ponto = 1'b1;
            wait_novo(COOLDOWN + 20, lat);
            check("l1_latency_bound", 32'(lat <= COOLDOWN + 10), 1);
            check("l1_range", 32'(position_led < 3'(N_POS)), 1);
            check("l1_differs", 32'(position_led != pos_prev), 1);
            pos_prev = position_led;
            check_publish();
            ganhou_ponto = 1'b0;
            perdeu_ponto = 1'b0;
            @(negedge clock);
        end

        // Level 1 never times out
        tick = 1'b1;
        n_tmo = 0;
        c1 = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clock);
            if (timeout === 1'b1)   n_tmo++;
            if (novo_alvo === 1'b1) c1++;
        end
        check("l1_no_timeout", n_tmo, 0);
        check("l1_idle_no_novo", c1, 0);

        // Level 3: timeout after TIMEOUT_BASE/2 ticks, then a new target
        nivel_dificuldade = 2'd3;
        wait_timeout(TIMEOUT_BASE, lat);
        check("l3_timeout_ticks", lat, TIMEOUT_BASE / 2);
        wait_novo(12, lat);
        check("l3_retarget_bound", 32'(lat <= 9), 1);
        check_publish();

        // Level 2: one tick already counted during the pulse-width sample
        nivel_dificuldade = 2'd2;
        wait_timeout(2 * TIMEOUT_BASE, lat);
        check("l2_timeout_ticks", lat, TIMEOUT_BASE - 1);
        wait_novo(12, lat);
        check_publish();

        // Lowering the limit below the current count fires on the next tick
        for (int i = 0; i < 69; i++) @(negedge clock);
        check("l2_no_early_timeout", 32'(timeout), 0);
        nivel_dificuldade = 2'd3;
        wait_timeout(5, lat);
        check("level_drop_timeout", lat, 1);
        wait_novo(12, lat);
        check_publish();

        // Asynchronous reset mid-AGUARDA, sampled before any rising edge
        #2 reset = 1'b1;
        #1;
        check("async_rst_position", 32'(position_led), 0);
        check("async_rst_rodadas", 32'(rodadas), 0);
        check("async_rst_ativo", 32'(ativo), 0);
        check("async_rst_pulses", 32'({reset_nivel, novo_alvo, timeout}), 0);
        rod_model = 0;
        @(negedge clock);
        reset = 1'b0;
        tick  = 1'b0;
        nivel_dificuldade = 2'd0;
        @(negedge clock);
        exp_q.push_back(3'd1);
        iniciar = 1'b1;
        wait_novo(10, lat);
        check("post_reset_latency", lat, 2);
        check_publish();
        iniciar = 1'b0;

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/gerador_alvo.md
Name: gerador_alvo

Overview:
Produces the target LED position that the game comparator and scoring counters consume. It picks a new target whenever the level counters report a won or lost point, or when a per-level timeout expires. On each new target it issues a one-cycle level-counter reset. It sits upstream of the game controller and drives its position_led and reset_nivel inputs.

Parameters:
N_POS, 5, number of valid LED positions; position_led ranges 0..N_POS-1, legal range 2..8
COOLDOWN, 8, clocks spent in PAUSA after a point event before a new draw
TIMEOUT_BASE, 3000, tick count allowed in AGUARDA at level 2; level 3 uses TIMEOUT_BASE/2 (floor)
TIMEOUT_N, 12, width of the timeout counter; must satisfy TIMEOUT_BASE < 2^TIMEOUT_N
LFSR_SEED, 16'hACE1, reset value of the LFSR; must be nonzero

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high; forces every register to its reset value
iniciar  in  1  start request; sampled only in IDLE
parar  in  1  stop request; valid in any state; takes priority over every other input
tick  in  1  timeout enable; the same strobe that drives the level counters' conta
nivel_dificuldade  in  2  difficulty level, 0..3
ganhou_ponto  in  1  point won; level signal, may be held high
perdeu_ponto  in  1  point lost; level signal, may be held high
position_led  out  3  current target position, registered
reset_nivel  out  1  one-cycle pulse when a new target is published
novo_alvo  out  1  one-cycle pulse, coincident with reset_nivel
timeout  out  1  one-cycle pulse when the AGUARDA timer expires
ativo  out  1  high in every state except IDLE
rodadas  out  8  count of published targets; saturates at 255

Behaviour:
- Reset values: state IDLE, position_led 0, rodadas 0, all pulses 0, ativo 0, LFSR = LFSR_SEED, edge registers 0, all counters 0.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clock in every state.
  - The draw candidate is lfsr[2:0].
- Edge detection:
  - ganhou_ponto and perdeu_ponto are registered every clock.
  - An event is a rising edge of either signal (in & ~prev).
  - A held-high level never retriggers.
  - Simultaneous edges count as one event.
  - Events outside AGUARDA are discarded.
- FSM:
  - IDLE: iniciar goes to SORTEIA.
  - SORTEIA, level 0: next target = (position_led+1) mod N_POS; go to PUBLICA.
  - SORTEIA, levels 1-3: accept the candidate if it is < N_POS and != position_led, then go to PUBLICA. Otherwise stay in SORTEIA and increment the retry counter.
  - SORTEIA retry limit: the 8th consecutive rejection forces (position_led+1) mod N_POS. Worst-case draw is therefore 8 cycles.
  - PUBLICA (1 cycle): register position_led ← chosen target; pulse reset_nivel and novo_alvo; rodadas++ (saturating); clear the timeout counter; go to AGUARDA.
  - AGUARDA: an event goes to PAUSA.
  - AGUARDA, levels 2-3: each tick increments the timeout counter. On reaching the level limit, pulse timeout for one cycle and go to SORTEIA; no PAUSA on timeout.
  - AGUARDA, levels 0-1: the timeout counter is never incremented and no timeout occurs.
  - PAUSA: count COOLDOWN clocks, then go to SORTEIA. COOLDOWN=0 goes to SORTEIA next cycle.
- Latency:
  - iniciar to novo_alvo: 2 clocks, plus draw retries.
  - Event edge to novo_alvo: COOLDOWN+3 clocks, plus draw retries.
- nivel_dificuldade is sampled live. A change during AGUARDA applies the new timeout limit against the current count: if count >= new limit, timeout fires on the next tick.
- parar: in any state goes to IDLE next clock. position_led and rodadas hold their values; the timeout and cooldown counters clear. Pulses never fire in the cycle parar is sampled.
- A new iniciar after parar does not clear rodadas; only reset clears it.
- Reset asserted mid-operation returns everything to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package gerador_alvo_pkg holds:
  - state encoding (IDLE, SORTEIA, PUBLICA, AGUARDA, PAUSA);
  - level codes NIVEL_0..NIVEL_3;
  - LFSR tap mask 16'hB400;
  - the retry limit 8.
- One sub-module: lfsr_galois (params WIDTH, TAPS, SEED; ports clock, reset, Q), free-running.

Test Plan:
- Reset check: reset pulse mid-AGUARDA -> position_led=0, rodadas=0, ativo=0, no pulses, with no clock edge required.
- Level 0 sequence: nivel=0, iniciar -> novo_alvo and reset_nivel 1-cycle pulses 2 clocks later, position_led=1. Each ganhou edge -> next value 2,3,4, then wraps to 0, each novo_alvo exactly COOLDOWN+3 clocks after the edge; rodadas=5 after 5 targets.
- Level 1 draws: nivel=1, 30 alternating ganhou/perdeu edges -> every position_led < 5 and != previous value; each novo_alvo within COOLDOWN+10 clocks of the edge; no timeout after 10000 ticks idle.
- Level 3 timeout: nivel=3, TIMEOUT_BASE=100, tick every clock, no events -> timeout pulse after 50 ticks in AGUARDA, followed by a new target; with nivel=2 the timeout comes after 100 ticks.
- Edge handling: ganhou held high 200 clocks -> exactly one novo_alvo; ganhou and perdeu rising in the same cycle -> exactly one novo_alvo; an edge during PAUSA -> ignored.
- Stop behaviour: parar during PAUSA -> ativo=0 next clock, no novo_alvo for 100 clocks, position_led unchanged. Subsequent iniciar -> rodadas continues from its prior value.
